s_axi_stream_sink: RTL and testbench
====================================

S_AXI_STREAM_SINK -- requirements
Module: s_axi_stream_sink

Interface
REQ-001 Parameter DWIDTH, default 32, stream data width in bits; multiple of 8.
REQ-002 Parameter BUFSIZE, default 8, log2 of frame buffer depth; WORDS = 2**BUFSIZE (default 256).
REQ-003 Port clk  input  1  single clock; all logic on rising edge.
REQ-004 Port xrst  input  1  reset, synchronous, active-low.
REQ-005 Port tvalid  input  1  upstream beat valid.
REQ-006 Port tready  output  1  sink ready to accept a beat.
REQ-007 Port tdata  input  DWIDTH  beat data.
REQ-008 Port tstrb  input  DWIDTH/8  byte-lane strobes.
REQ-009 Port tlast  input  1  final beat of frame.
REQ-010 Port clr  input  1  pulse: release buffer and rearm for the next frame.
REQ-011 Port rd_addr  input  BUFSIZE  buffer read address.
REQ-012 Port rd_data  output  DWIDTH  buffer read data.
REQ-013 Port done  output  1  frame captured; buffer stable.
REQ-014 Port len_err  output  1  frame length was not exactly WORDS beats.
REQ-015 Port beat_count  output  BUFSIZE+1  beats accepted in the current frame.
REQ-016 Port checksum  output  DWIDTH  modulo-2**DWIDTH sum of accepted masked beats.

Function
REQ-017 The FSM SHALL have states S_IDLE, S_RECV and S_DONE; illegal encodings go to S_IDLE.
REQ-018 S_IDLE SHALL move to S_RECV unconditionally on the next cycle.
REQ-019 tready SHALL be 1 exactly when state is S_RECV; it is decoded from state with no extra register.
REQ-020 A beat SHALL be accepted only in a cycle where tvalid and tready are both 1; otherwise tdata, tstrb and tlast are ignored.
REQ-021 An accepted beat SHALL write mem[wr_ptr] with tdata. Byte lanes whose tstrb bit is 0 are written as 0x00.
REQ-022 An accepted beat SHALL increment wr_ptr and beat_count by 1, and add the masked beat to checksum with wrap-around.
REQ-023 An accepted beat with tlast=1 SHALL move S_RECV to S_DONE, and set len_err=1 when that beat's index (wr_ptr before increment) is not WORDS-1.
REQ-024 An accepted beat with tlast=0 at index WORDS-1 SHALL move S_RECV to S_DONE with len_err=1 (overflow), so no beat is ever accepted past WORDS.
REQ-025 Any tlast value is ignored when tvalid=0.
REQ-026 done SHALL be 1 exactly when state is S_DONE; it asserts the cycle after the final accepted beat.
REQ-027 beat_count, checksum and len_err SHALL hold their values throughout S_DONE.
REQ-028 clr=1 in S_DONE SHALL go to S_IDLE and zero wr_ptr, beat_count, checksum and len_err on the same edge.
REQ-029 clr SHALL be ignored in S_IDLE and S_RECV.
REQ-030 rd_data SHALL equal mem[rd_addr] one cycle after rd_addr is sampled, in any state.
REQ-031 A read of the address being written in the same cycle SHALL return the old contents.
REQ-032 Buffer memory SHALL NOT be reset; reading a location not written since the last clear returns undefined data.

Reset
REQ-033 While xrst=0 at a clock edge, state SHALL become S_IDLE and wr_ptr, beat_count, checksum, len_err, done and tready SHALL become 0.
REQ-034 rd_data SHALL reset to 0.
REQ-035 Reset asserted mid-frame SHALL abandon the frame; after release, capture restarts at index 0.
REQ-036 The first cycle after reset release is S_IDLE (tready=0); tready=1 from the second cycle.

Verification
REQ-037 Full frame: data 1..256, tstrb all ones, tlast on beat 256, tvalid continuous -> done=1 the cycle after, beat_count=256, checksum=32896, len_err=0; rd_addr=5 -> rd_data=6 next cycle.
REQ-038 Bubbles: same frame with tvalid toggling 1/0 every cycle -> same done, beat_count, checksum, len_err and buffer contents as REQ-037.
REQ-039 Early tlast on beat 10 (data 1..10) -> done=1, beat_count=10, checksum=55, len_err=1, tready=0 from the next cycle.
REQ-040 256 beats with no tlast, tvalid held high -> done=1, len_err=1, beat_count=256; the 257th beat is not accepted (tready=0).
REQ-041 Strobe mask: beat 0 tdata=0xAABBCCDD, tstrb=4'b0011 -> mem[0]=0x0000CCDD and checksum includes 0x0000CCDD.
REQ-042 Reset mid-frame after beat 100, then clr sequencing: xrst=0 for one cycle -> beat_count=0, tready=0 that cycle; a subsequent full frame passes REQ-037. clr pulse in S_DONE -> done=0 next cycle, tready=1 one cycle later.

Source files
------------

// File: rtl/s_axi_stream_sink.sv
// AXI-Stream frame sink: captures one frame of up to 2**BUFSIZE beats into a local buffer,
// tracking beat count, a running checksum and a length error, then holds until cleared.
module s_axi_stream_sink #(
  parameter int unsigned DWIDTH  = 32,
  parameter int unsigned BUFSIZE = 8
) (
  input  logic                 clk,
  input  logic                 xrst,
  input  logic                 tvalid,
  output logic                 tready,
  input  logic [DWIDTH-1:0]    tdata,
  input  logic [DWIDTH/8-1:0]  tstrb,
  input  logic                 tlast,
  input  logic                 clr,
  input  logic [BUFSIZE-1:0]   rd_addr,
  output logic [DWIDTH-1:0]    rd_data,
  output logic                 done,
  output logic                 len_err,
  output logic [BUFSIZE:0]     beat_count,
  output logic [DWIDTH-1:0]    checksum
);

  localparam int unsigned Words = 2 ** BUFSIZE;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RECV = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e             state;
  logic [BUFSIZE-1:0] wr_ptr;
  logic [DWIDTH-1:0]  masked;
  logic               accept;
  logic               last_idx;

  logic [DWIDTH-1:0]  mem [Words];

  assign tready   = (state == S_RECV);
  assign done     = (state == S_DONE);
  assign accept   = tvalid && tready;
  assign last_idx = (wr_ptr == {BUFSIZE{1'b1}});

  // Lanes with a cleared strobe contribute zero to both the buffer and the checksum.
  always_comb begin
    masked = '0;
    for (int b = 0; b < DWIDTH / 8; b++) begin
      if (tstrb[b]) masked[b*8 +: 8] = tdata[b*8 +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (!xrst) begin
      state      <= S_IDLE;
      wr_ptr     <= '0;
      beat_count <= '0;
      checksum   <= '0;
      len_err    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: state <= S_RECV;
        S_RECV: begin
          if (accept) begin
            wr_ptr     <= wr_ptr + BUFSIZE'(1);
            beat_count <= beat_count + (BUFSIZE + 1)'(1);
            checksum   <= checksum + masked;
            // Frame ends on tlast or on the last slot; only tlast on the last slot is clean.
            if (tlast || last_idx) begin
              state   <= S_DONE;
              len_err <= !(tlast && last_idx);
            end
          end
        end
        S_DONE: begin
          if (clr) begin
            state      <= S_IDLE;
            wr_ptr     <= '0;
            beat_count <= '0;
            checksum   <= '0;
            len_err    <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr] <= masked;
  end

  always_ff @(posedge clk) begin
    if (!xrst) rd_data <= '0;
    else       rd_data <= mem[rd_addr];
  end

endmodule

// File: tb/tb_s_axi_stream_sink.sv
// Directed bench for s_axi_stream_sink: full, bubbled, short, overflowing and strobed frames,
// clear sequencing and mid-frame reset.
module tb_s_axi_stream_sink;

  localparam int unsigned DW = 32;
  localparam int unsigned BS = 8;

  logic            clk = 1'b0;
  logic            xrst;
  logic            tvalid;
  logic            tready;
  logic [DW-1:0]   tdata;
  logic [DW/8-1:0] tstrb;
  logic            tlast;
  logic            clr;
  logic [BS-1:0]   rd_addr;
  logic [DW-1:0]   rd_data;
  logic            done;
  logic            len_err;
  logic [BS:0]     beat_count;
  logic [DW-1:0]   checksum;

  int checks   = 0;
  int failures = 0;

  s_axi_stream_sink #(.DWIDTH(DW), .BUFSIZE(BS)) dut (
    .clk        (clk),
    .xrst       (xrst),
    .tvalid     (tvalid),
    .tready     (tready),
    .tdata      (tdata),
    .tstrb      (tstrb),
    .tlast      (tlast),
    .clr        (clr),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .done       (done),
    .len_err    (len_err),
    .beat_count (beat_count),
    .checksum   (checksum)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Beat i carries data first+i; idle cycles between beats carry junk with tlast=1.
  task automatic send_frame(input int n, input int first, input bit last_end, input bit bubbles);
    for (int i = 0; i < n; i++) begin
      tvalid = 1'b1;
      tdata  = DW'(first + i);
      tstrb  = '1;
      tlast  = last_end && (i == n - 1);
      tick();
      if (bubbles && i != n - 1) begin
        tvalid = 1'b0;
        tlast  = 1'b1;
        tdata  = '1;
        tick();
      end
    end
    tvalid = 1'b0;
    tlast  = 1'b0;
  endtask

  task automatic read_chk(input string tag, input int addr, input logic [63:0] exp);
    rd_addr = BS'(addr);
    tick();
    chk(tag, 64'(rd_data), exp);
  endtask

  task automatic clr_rearm();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    tick();
  endtask

  initial begin
    xrst = 1'b0; tvalid = 1'b0; tdata = '0; tstrb = '0; tlast = 1'b0; clr = 1'b0; rd_addr = '0;
    tick();
    tick();
    chk("rst_tready", 64'(tready), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_count", 64'(beat_count), 64'd0);
    chk("rst_checksum", 64'(checksum), 64'd0);
    chk("rst_len_err", 64'(len_err), 64'd0);
    chk("rst_rd_data", 64'(rd_data), 64'd0);

    xrst = 1'b1;
    chk("rel_idle_tready", 64'(tready), 64'd0);
    tick();
    chk("rel_tready", 64'(tready), 64'd1);

    // Full frame, continuous valid
    send_frame(255, 1, 1'b0, 1'b0);
    chk("full_not_done_early", 64'(done), 64'd0);
    send_frame(1, 256, 1'b1, 1'b0);
    chk("full_done", 64'(done), 64'd1);
    chk("full_count", 64'(beat_count), 64'd256);
    chk("full_checksum", 64'(checksum), 64'd32896);
    chk("full_len_err", 64'(len_err), 64'd0);
    chk("full_tready", 64'(tready), 64'd0);
    read_chk("full_rd5", 5, 64'd6);
    read_chk("full_rd0", 0, 64'd1);
    read_chk("full_rd255", 255, 64'd256);

    // Traffic in S_DONE must not disturb the captured results
    tvalid = 1'b1; tlast = 1'b1; tdata = 32'h1234;
    tick();
    tick();
    tvalid = 1'b0; tlast = 1'b0;
    chk("hold_count", 64'(beat_count), 64'd256);
    chk("hold_checksum", 64'(checksum), 64'd32896);
    chk("hold_done", 64'(done), 64'd1);

    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("clr_done", 64'(done), 64'd0);
    chk("clr_tready_idle", 64'(tready), 64'd0);
    chk("clr_count", 64'(beat_count), 64'd0);
    chk("clr_checksum", 64'(checksum), 64'd0);
    tick();
    chk("clr_tready", 64'(tready), 64'd1);

    // Bubbled frame
    send_frame(256, 1, 1'b1, 1'b1);
    chk("bub_done", 64'(done), 64'd1);
    chk("bub_count", 64'(beat_count), 64'd256);
    chk("bub_checksum", 64'(checksum), 64'd32896);
    chk("bub_len_err", 64'(len_err), 64'd0);
    read_chk("bub_rd5", 5, 64'd6);
    read_chk("bub_rd100", 100, 64'd101);
    read_chk("bub_rd200", 200, 64'd201);

    // Early tlast at beat 10, with clr held during the first beats
    clr_rearm();
    clr = 1'b1;
    send_frame(5, 1, 1'b0, 1'b0);
    clr = 1'b0;
    send_frame(5, 6, 1'b1, 1'b0);
    chk("early_done", 64'(done), 64'd1);
    chk("early_count", 64'(beat_count), 64'd10);
    chk("early_checksum", 64'(checksum), 64'd55);
    chk("early_len_err", 64'(len_err), 64'd1);
    chk("early_tready", 64'(tready), 64'd0);

    // Overflow: 256 beats without tlast, then a 257th attempt
    clr_rearm();
    send_frame(256, 1, 1'b0, 1'b0);
    chk("ovf_done", 64'(done), 64'd1);
    chk("ovf_len_err", 64'(len_err), 64'd1);
    chk("ovf_count", 64'(beat_count), 64'd256);
    chk("ovf_tready", 64'(tready), 64'd0);
    send_frame(1, 32'h1000, 1'b0, 1'b0);
    chk("ovf_257_count", 64'(beat_count), 64'd256);
    chk("ovf_257_checksum", 64'(checksum), 64'd32896);
    read_chk("ovf_rd0", 0, 64'd1);

    // Strobe masking; read of index 0 while it is written returns the old word
    clr_rearm();
    rd_addr = '0;
    tvalid = 1'b1; tdata = 32'hAABBCCDD; tstrb = 4'b0011; tlast = 1'b0;
    tick();
    chk("rdw_old", 64'(rd_data), 64'd1);
    tdata = 32'h11223344; tstrb = 4'b1100; tlast = 1'b1;
    tick();
    tvalid = 1'b0; tlast = 1'b0;
    chk("strb_rd0", 64'(rd_data), 64'h0000CCDD);
    chk("strb_checksum", 64'(checksum), 64'h1122CCDD);
    chk("strb_count", 64'(beat_count), 64'd2);
    chk("strb_len_err", 64'(len_err), 64'd1);
    read_chk("strb_rd1", 1, 64'h11220000);

    // Reset after beat 100 abandons the frame
    clr_rearm();
    send_frame(100, 1, 1'b0, 1'b0);
    rd_addr = 8'd5;
    tick();
    chk("pre_rst_rd5", 64'(rd_data), 64'd6);
    xrst = 1'b0;
    tick();
    chk("mid_rst_count", 64'(beat_count), 64'd0);
    chk("mid_rst_tready", 64'(tready), 64'd0);
    chk("mid_rst_checksum", 64'(checksum), 64'd0);
    chk("mid_rst_rd_data", 64'(rd_data), 64'd0);
    xrst = 1'b1;
    tick();
    chk("mid_rel_tready", 64'(tready), 64'd1);
    send_frame(256, 1, 1'b1, 1'b0);
    chk("after_rst_done", 64'(done), 64'd1);
    chk("after_rst_count", 64'(beat_count), 64'd256);
    chk("after_rst_checksum", 64'(checksum), 64'd32896);
    chk("after_rst_len_err", 64'(len_err), 64'd0);
    read_chk("after_rst_rd5", 5, 64'd6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
